esc_encoder: RTL and testbench

- Escape-mode transmitter for the C-PHY low-power lane; it is the master-side counterpart of the slave escape decoder.
- Serialises one 8-bit escape command MSB-first on line A at one bit per clk (RxClkEsc-rate domain).
- For LPDT, follows the command with back-to-back data bytes, MSB-first, fetched through a valid/ready handshake.
- Terminates every sequence with a one-cycle stop state (A=B=C=1), which the decoder detects as end of escape.

---
 rtl/esc_encoder.sv | 189 ++++++++++++++++++
 tb/tb_esc_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/esc_encoder.sv
// C-PHY escape-mode transmitter: serialises an 8-bit escape command (plus LPDT payload bytes) MSB-first
// on lane A, ending every sequence with a one-cycle 111 stop state. Optional macro: ESC_TX_STATUS_EN (TxByteCount).
module esc_encoder #(
   parameter logic [7:0] CMD_LPDT = 8'hE1,
   parameter logic [7:0] CMD_ULPS = 8'h1E,
   parameter logic [7:0] CMD_TRIG = 8'h62
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       TxRequestEsc,
   input  logic       TxLpdtEsc,
   input  logic       TxUlpsEsc,
   input  logic [3:0] TxTriggerEsc,
   input  logic [7:0] TxDataEsc,
   input  logic       TxValidEsc,
   output logic       TxReadyEsc,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       EscEncoderActive,
   output logic       ErrTxCmd,
   output logic       ErrUnderflow
`ifdef ESC_TX_STATUS_EN
   ,
   output logic [7:0] TxByteCount
`endif
);

   // Handshake: a byte moves when TxReadyEsc && TxValidEsc at a rising clk edge. TxReadyEsc is only
   // offered on the last bit of a byte slot, so the accepted byte's MSB follows with no gap.

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CMD       = 3'd1,
      LPDT      = 3'd2,
      ULPS_HOLD = 3'd3,
      STOP      = 3'd4
   } escState_t;

   localparam logic [1:0] MODE_LPDT = 2'd0;
   localparam logic [1:0] MODE_ULPS = 2'd1;
   localparam logic [1:0] MODE_TRIG = 2'd2;

   escState_t  state;
   escState_t  nextState;
   logic [2:0] bitCnt;
   logic [7:0] shiftReg;
   logic [1:0] mode;
   logic       armed;

   logic       selTrig;
   logic       trigBad;
   logic [1:0] selCount;
   logic       validSel;
   logic       idleReq;
   logic       loadCmd;
   logic       cmdErr;
   logic       lastBit;
   logic       boundary;
   logic       transfer;
   logic       underflow;
   logic [7:0] cmdCode;
   logic [1:0] selMode;
   logic       nextA;
   logic       nextB;
   logic       nextC;

   assign selTrig  = (TxTriggerEsc == 4'b0001);
   assign trigBad  = (TxTriggerEsc != 4'b0000) && !selTrig;
   assign selCount = {1'b0, TxLpdtEsc} + {1'b0, TxUlpsEsc} + {1'b0, selTrig};
   assign validSel = (selCount == 2'd1) && !trigBad;
   // armed blocks repeated error pulses until the request is released
   assign idleReq  = (state == IDLE) && TxRequestEsc && armed;
   assign loadCmd  = idleReq && validSel;
   assign cmdErr   = idleReq && !validSel;

   assign lastBit    = (bitCnt == 3'd7);
   assign boundary   = lastBit && (((state == CMD) && (mode == MODE_LPDT)) || (state == LPDT));
   assign TxReadyEsc = boundary && TxRequestEsc;
   assign transfer   = TxReadyEsc && TxValidEsc;
   assign underflow  = boundary && TxRequestEsc && !TxValidEsc;

   always_comb begin
      cmdCode = CMD_TRIG;
      selMode = MODE_TRIG;
      if (TxLpdtEsc) begin
         cmdCode = CMD_LPDT;
         selMode = MODE_LPDT;
      end else if (TxUlpsEsc) begin
         cmdCode = CMD_ULPS;
         selMode = MODE_ULPS;
      end
   end

   // State register
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (loadCmd) nextState = CMD;
         CMD: begin
            if (lastBit) begin
               case (mode)
                  MODE_LPDT: nextState = transfer ? LPDT : STOP;
                  MODE_ULPS: nextState = ULPS_HOLD;
                  default:   nextState = STOP;
               endcase
            end
         end
         LPDT:      if (lastBit) nextState = transfer ? LPDT : STOP;
         ULPS_HOLD: if (!TxRequestEsc) nextState = STOP;
         STOP:      nextState = IDLE;
         default:   nextState = IDLE;
      endcase
   end

   // Output logic: lane symbol selected by the current state, registered below
   always_comb begin
      nextA = 1'b1;
      nextB = 1'b1;
      nextC = 1'b1;
      case (state)
         CMD, LPDT: begin
            nextA = shiftReg[7];
            nextB = ~shiftReg[7];
            nextC = 1'b0;
         end
         ULPS_HOLD: begin
            nextA = 1'b0;
            nextB = 1'b0;
            nextC = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         A                <= 1'b1;
         B                <= 1'b1;
         C                <= 1'b1;
         EscEncoderActive <= 1'b0;
         ErrTxCmd         <= 1'b0;
         ErrUnderflow     <= 1'b0;
      end else begin
         A                <= nextA;
         B                <= nextB;
         C                <= nextC;
         EscEncoderActive <= (state != IDLE);
         ErrTxCmd         <= cmdErr;
         ErrUnderflow     <= underflow;
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         bitCnt   <= 3'd0;
         shiftReg <= 8'd0;
         mode     <= MODE_LPDT;
         armed    <= 1'b1;
      end else begin
         if (cmdErr)             armed <= 1'b0;
         else if (!TxRequestEsc) armed <= 1'b1;

         if (loadCmd) begin
            bitCnt   <= 3'd0;
            shiftReg <= cmdCode;
            mode     <= selMode;
         end else if ((state == CMD) || (state == LPDT)) begin
            bitCnt   <= bitCnt + 3'd1;
            shiftReg <= transfer ? TxDataEsc : {shiftReg[6:0], 1'b0};
         end
      end
   end

`ifdef ESC_TX_STATUS_EN
   always_ff @(posedge clk or negedge RST) begin
      if (!RST)                                 TxByteCount <= 8'd0;
      else if (loadCmd)                         TxByteCount <= 8'd0;
      else if (transfer && TxByteCount != 8'hFF) TxByteCount <= TxByteCount + 8'd1;
   end
`endif

endmodule

// File: tb/tb_esc_encoder.sv
// Directed bench for esc_encoder: LPDT, ULPS, trigger, illegal selections, underflow and async reset,
// plus the byte counter when ESC_TX_STATUS_EN is defined.
module tb_esc_encoder;

   logic       clk;
   logic       RST;
   logic       TxRequestEsc;
   logic       TxLpdtEsc;
   logic       TxUlpsEsc;
   logic [3:0] TxTriggerEsc;
   logic [7:0] TxDataEsc;
   logic       TxValidEsc;
   logic       TxReadyEsc;
   logic       A;
   logic       B;
   logic       C;
   logic       EscEncoderActive;
   logic       ErrTxCmd;
   logic       ErrUnderflow;
`ifdef ESC_TX_STATUS_EN
   logic [7:0] TxByteCount;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [63:0] stream;
   int          nBits, nHold, nStop, nActive, nReady, nXfer, nUf, nCmdErr, badCode;
   bit          seqDone;

   esc_encoder dut (
      .clk(clk), .RST(RST),
      .TxRequestEsc(TxRequestEsc), .TxLpdtEsc(TxLpdtEsc), .TxUlpsEsc(TxUlpsEsc),
      .TxTriggerEsc(TxTriggerEsc), .TxDataEsc(TxDataEsc), .TxValidEsc(TxValidEsc),
      .TxReadyEsc(TxReadyEsc), .A(A), .B(B), .C(C),
      .EscEncoderActive(EscEncoderActive), .ErrTxCmd(ErrTxCmd), .ErrUnderflow(ErrUnderflow)
`ifdef ESC_TX_STATUS_EN
      , .TxByteCount(TxByteCount)
`endif
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idleInputs();
      TxRequestEsc = 1'b0;
      TxLpdtEsc    = 1'b0;
      TxUlpsEsc    = 1'b0;
      TxTriggerEsc = 4'd0;
      TxValidEsc   = 1'b0;
      TxDataEsc    = 8'd0;
   endtask

   function automatic logic [7:0] byteFor(input int k, input logic [7:0] b1);
      logic [7:0] v;
      v = 8'(k * 7 + 3);
      return (k == 1) ? b1 : v;
   endfunction

   // Drives one escape sequence and records what appears on the lane until activity ends.
   task automatic runSeq(input logic lpdt, input logic ulps, input logic [3:0] trig, input logic valid,
                         input int dropXfers, input int dropHolds, input logic [7:0] b0, input logic [7:0] b1);
      bit seenActive;
      bit pendingXfer;
      seenActive = 0;
      pendingXfer = 0;
      seqDone = 0;
      stream = 64'd0;
      nBits = 0; nHold = 0; nStop = 0; nActive = 0; nReady = 0; nXfer = 0; nUf = 0; nCmdErr = 0; badCode = 0;
      TxLpdtEsc = lpdt; TxUlpsEsc = ulps; TxTriggerEsc = trig;
      TxValidEsc = valid; TxDataEsc = b0; TxRequestEsc = 1'b1;
      for (int s = 0; s < 4000 && !seqDone; s++) begin
         tick();
         if (pendingXfer) TxDataEsc = byteFor(nXfer, b1);
         pendingXfer = 0;
         if ((nXfer >= dropXfers && nHold >= dropHolds) || nUf > 0) TxRequestEsc = 1'b0;
         if (EscEncoderActive) begin
            seenActive = 1;
            nActive++;
            if ({A, B, C} == 3'b111) nStop++;
            else if ({A, B, C} == 3'b000) nHold++;
            else if (B == ~A && C == 1'b0) begin
               stream = {stream[62:0], A};
               nBits++;
            end else badCode++;
         end else begin
            if (seenActive) seqDone = 1;
            if ({A, B, C} != 3'b111) badCode++;
         end
         if (ErrUnderflow) nUf++;
         if (ErrTxCmd) nCmdErr++;
         if (TxReadyEsc) nReady++;
         if (TxReadyEsc && TxValidEsc) begin
            nXfer++;
            pendingXfer = 1;
         end
      end
      check("seq_done", 64'(seqDone), 64'd1);
      idleInputs();
      tick();
      tick();
   endtask

   // Holds an illegal selection for several cycles; exactly one error pulse and no lane activity expected.
   task automatic runBad(input string tag, input logic lpdt, input logic ulps, input logic [3:0] trig);
      int pulses;
      int activity;
      pulses = 0;
      activity = 0;
      TxLpdtEsc = lpdt; TxUlpsEsc = ulps; TxTriggerEsc = trig; TxRequestEsc = 1'b1;
      for (int s = 0; s < 6; s++) begin
         tick();
         if (ErrTxCmd) pulses++;
         if (EscEncoderActive || {A, B, C} != 3'b111) activity++;
      end
      check({tag, "_pulses"}, 64'(pulses), 64'd1);
      check({tag, "_quiet"}, 64'(activity), 64'd0);
      idleInputs();
      tick();
      tick();
   endtask

   initial begin
      idleInputs();
      RST = 1'b0;
      tick();
      tick();
      check("rst_lines", {61'd0, A, B, C}, 64'h7);
      check("rst_active", 64'(EscEncoderActive), 64'd0);
      check("rst_ready", 64'(TxReadyEsc), 64'd0);
      check("rst_errs", {62'd0, ErrTxCmd, ErrUnderflow}, 64'd0);
      check("rst_state", 64'(dut.state), 64'd0);
`ifdef ESC_TX_STATUS_EN
      check("rst_count", 64'(TxByteCount), 64'd0);
`endif
      RST = 1'b1;
      tick();

      // LPDT: E1, A5, 3C then stop
      runSeq(1'b1, 1'b0, 4'd0, 1'b1, 2, 0, 8'hA5, 8'h3C);
      check("lpdt_stream", stream, 64'hE1A53C);
      check("lpdt_bits", 64'(nBits), 64'd24);
      check("lpdt_stop", 64'(nStop), 64'd1);
      check("lpdt_active", 64'(nActive), 64'd25);
      check("lpdt_ready", 64'(nReady), 64'd2);
      check("lpdt_xfer", 64'(nXfer), 64'd2);
      check("lpdt_uf", 64'(nUf), 64'd0);
      check("lpdt_bad", 64'(badCode), 64'd0);

      // ULPS: 1E, hold while requested, stop
      runSeq(1'b0, 1'b1, 4'd0, 1'b0, 0, 20, 8'h00, 8'h00);
      check("ulps_stream", stream, 64'h1E);
      check("ulps_hold", 64'(nHold), 64'd22);
      check("ulps_stop", 64'(nStop), 64'd1);
      check("ulps_active", 64'(nActive), 64'd31);
      check("ulps_ready", 64'(nReady), 64'd0);
      check("ulps_bad", 64'(badCode), 64'd0);

      // Reset trigger: 62 then stop
      runSeq(1'b0, 1'b0, 4'b0001, 1'b0, 0, 0, 8'h00, 8'h00);
      check("trig_stream", stream, 64'h62);
      check("trig_bits", 64'(nBits), 64'd8);
      check("trig_stop", 64'(nStop), 64'd1);
      check("trig_active", 64'(nActive), 64'd9);
      check("trig_hold", 64'(nHold), 64'd0);

      // Illegal selections
      runBad("bad_trig2", 1'b0, 1'b0, 4'b0010);
      runBad("bad_multi", 1'b1, 1'b1, 4'd0);
      runBad("bad_none", 1'b0, 1'b0, 4'd0);
      runBad("bad_lpdt_trig", 1'b1, 1'b0, 4'b0001);

      // Underflow at the first byte boundary
      runSeq(1'b1, 1'b0, 4'd0, 1'b0, 999, 0, 8'h00, 8'h00);
      check("uf_stream", stream, 64'hE1);
      check("uf_bits", 64'(nBits), 64'd8);
      check("uf_pulse", 64'(nUf), 64'd1);
      check("uf_ready", 64'(nReady), 64'd1);
      check("uf_active", 64'(nActive), 64'd9);
      check("uf_stop", 64'(nStop), 64'd1);

      // LPDT ended by request drop at the first boundary: no underflow
      runSeq(1'b1, 1'b0, 4'd0, 1'b1, 0, 0, 8'h55, 8'h00);
      check("drop_bits", 64'(nBits), 64'd8);
      check("drop_uf", 64'(nUf), 64'd0);
      check("drop_xfer", 64'(nXfer), 64'd0);

`ifdef ESC_TX_STATUS_EN
      runSeq(1'b1, 1'b0, 4'd0, 1'b1, 300, 0, 8'h11, 8'h22);
      check("cnt300_xfer", 64'(nXfer), 64'd300);
      check("cnt300_bits", 64'(nBits), 64'd2408);
      check("cnt300_sat", 64'(TxByteCount), 64'd255);
      runSeq(1'b1, 1'b0, 4'd0, 1'b1, 3, 0, 8'h33, 8'h44);
      check("cnt3", 64'(TxByteCount), 64'd3);
`endif

      // Async reset in the middle of LPDT while TxReadyEsc is offered
      TxLpdtEsc = 1'b1; TxValidEsc = 1'b1; TxDataEsc = 8'h99; TxRequestEsc = 1'b1;
      for (int s = 0; s < 8; s++) tick();
      check("pre_rst_ready", 64'(TxReadyEsc), 64'd1);
      check("pre_rst_lines", {61'd0, A, B, C}, 64'h2);
      #2;
      RST = 1'b0;
      #1;
      check("arst_lines", {61'd0, A, B, C}, 64'h7);
      check("arst_ready", 64'(TxReadyEsc), 64'd0);
      check("arst_active", 64'(EscEncoderActive), 64'd0);
      check("arst_state", 64'(dut.state), 64'd0);
      idleInputs();
      tick();
      RST = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
